// File: rtl/apb_ic_pkg.sv
// apb_ic_pkg: constants and types shared between apb_interconnect and the blocks around it.
package apb_ic_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int DROP_CNT_W = 16;

    typedef logic [DATA_WIDTH-1:0] ic_data_t;

endpackage

// File: rtl/apb_rx_fifo_mem.sv
// apb_rx_fifo_mem: DEPTH x DATA_WIDTH register array for the receive FIFO.
// It has one clocked write port and one asynchronous read port, and is never reset.
module apb_rx_fifo_mem #(
    parameter int DATA_WIDTH = apb_ic_pkg::DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                     pclk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/apb_slave_rx_fifo.sv
// apb_slave_rx_fifo: show-ahead receive FIFO behind one apb_interconnect slave port.
// It drops beats while full and flags them. Define RX_DROP_CNT_EN to add the saturating drop_cnt port.
module apb_slave_rx_fifo #(
    parameter int DATA_WIDTH = apb_ic_pkg::DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = 6
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    slave_data,
    input  logic                     slave_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     ovf_clr
`ifdef RX_DROP_CNT_EN
    ,
    output logic [apb_ic_pkg::DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_afull;
    logic                  r_ovf;
    logic [LW-1:0]         w_level_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_head;

    apb_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .pclk  (pclk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (slave_data),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // A pop frees the slot in the same cycle, so a beat arriving while full is still accepted.
    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && rd_ready;
    assign w_push  = slave_valid && (!w_full || w_pop);
    assign w_drop  = slave_valid && w_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_afull  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= w_level_nxt;
            r_afull <= (w_level_nxt >= AFULL_L);
        end
    end

    // A drop in the same cycle as ovf_clr wins, so no loss goes unreported.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef RX_DROP_CNT_EN
    localparam logic [apb_ic_pkg::DROP_CNT_W-1:0] CNT_MAX = '1;
    logic [apb_ic_pkg::DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_drop_cnt <= w_drop ? apb_ic_pkg::DROP_CNT_W'(1) : '0;
        end else if (w_drop && (r_drop_cnt != CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + apb_ic_pkg::DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign rd_valid    = !w_empty;
    assign rd_data     = w_empty ? '0 : w_head;
    assign level       = r_level;
    assign almost_full = r_afull;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_apb_slave_rx_fifo.sv
// tb_apb_slave_rx_fifo: self-checking bench for apb_slave_rx_fifo against a queue-based reference model.
// Define RX_DROP_CNT_EN to also check drop_cnt.
`timescale 1ns/1ps
module tb_apb_slave_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic        pclk;
    logic        reset;
    logic [31:0] slave_data;
    logic        slave_valid;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  level;
    logic        almost_full;
    logic        overflow;
    logic        ovf_clr;
`ifdef RX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    bit          m_ovf;
    int          m_cnt;

    apb_slave_rx_fifo dut (
        .pclk        (pclk),
        .reset       (reset),
        .slave_data  (slave_data),
        .slave_valid (slave_valid),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
`ifdef RX_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial pclk = 1'b0;
    always #500 pclk = ~pclk;

    // Reference model: a queue of accepted beats plus the sticky-loss state, updated at each edge.
    task automatic tick(input logic sv, input logic [31:0] d, input logic rdy, input logic clr);
        bit pop;
        bit drop;
        slave_valid = sv;
        slave_data  = sv ? d : 32'h0;
        rd_ready    = rdy;
        ovf_clr     = clr;
        @(posedge pclk);
        pop  = (mq.size() != 0) && rdy;
        drop = sv && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (sv && !drop) mq.push_back(d);
        if (drop && clr) begin
            m_ovf = 1'b1;
            m_cnt = 1;
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        @(negedge pclk);
        slave_valid = 1'b0;
        rd_ready    = 1'b0;
        ovf_clr     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge pclk);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            total++; if (rd_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_rd_valid: got %0b want 0", rd_valid); end
            total++; if (level !== 4'd0)      begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
            total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_afull: got %0b want 0", almost_full); end
            total++; if (overflow !== 1'b0)   begin bad++; $display("[TB] FAIL reset_ovf: got %0b want 0", overflow); end
        end
        total++; if (rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_single_beat();
        do_reset();
        tick(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        total++; if (rd_valid !== 1'b1)      begin bad++; $display("[TB] FAIL single_valid: got %0b want 1", rd_valid); end
        total++; if (rd_data !== 32'hA5A5_0001) begin bad++; $display("[TB] FAIL single_data: got %h want a5a50001", rd_data); end
        total++; if (level !== 4'd1)         begin bad++; $display("[TB] FAIL single_level: got %0d want 1", level); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (level !== 4'd0)         begin bad++; $display("[TB] FAIL single_pop_level: got %0d want 0", level); end
        total++; if (rd_valid !== 1'b0)      begin bad++; $display("[TB] FAIL single_pop_valid: got %0b want 0", rd_valid); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (level !== 4'd0)         begin bad++; $display("[TB] FAIL empty_underflow: got %0d want 0", level); end
    endtask

    task automatic test_fill_overflow();
        int lv;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            tick(1'b1, 32'(i), 1'b0, 1'b0);
            lv = (i > DEPTH) ? DEPTH : i;
            total++; if (level !== 4'(lv)) begin bad++; $display("[TB] FAIL fill_level[%0d]: got %0d want %0d", i, level, lv); end
            total++; if (almost_full !== (lv >= AFULL)) begin bad++; $display("[TB] FAIL fill_afull[%0d]: got %0b want %0b", i, almost_full, lv >= AFULL); end
            total++; if (overflow !== (i == 9)) begin bad++; $display("[TB] FAIL fill_ovf[%0d]: got %0b want %0b", i, overflow, i == 9); end
        end
`ifdef RX_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL fill_drop_cnt: got %0d want 1", drop_cnt); end
`endif
        for (int k = 1; k <= 8; k++) begin
            total++; if (rd_data !== 32'(k)) begin bad++; $display("[TB] FAIL fill_order[%0d]: got %0d want %0d", k, rd_data, k); end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_beat9_absent: got %0b want 0", rd_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_order[8];
        do_reset();
        for (int i = 1; i <= 8; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
        tick(1'b1, 32'd10, 1'b1, 1'b0);
        total++; if (level !== 4'd8)    begin bad++; $display("[TB] FAIL pp_level: got %0d want 8", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL pp_ovf: got %0b want 0", overflow); end
        for (int k = 0; k < 7; k++) exp_order[k] = 32'(k + 2);
        exp_order[7] = 32'd10;
        for (int k = 0; k < 8; k++) begin
            total++; if (rd_data !== exp_order[k]) begin bad++; $display("[TB] FAIL pp_order[%0d]: got %0d want %0d", k, rd_data, exp_order[k]); end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear_race();
        do_reset();
        for (int i = 1; i <= 8; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
        tick(1'b1, 32'hBEEF, 1'b0, 1'b0);
        tick(1'b1, 32'hDEAD, 1'b0, 1'b1);
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL race_ovf: got %0b want 1", overflow); end
        total++; if (level !== 4'd8)    begin bad++; $display("[TB] FAIL race_level: got %0d want 8", level); end
`ifdef RX_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL race_drop_cnt: got %0d want 1", drop_cnt); end
`endif
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL clr_ovf: got %0b want 0", overflow); end
`ifdef RX_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL clr_drop_cnt: got %0d want 0", drop_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 9; i++) tick(1'b1, 32'(i + 100), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (level !== 4'd5)    begin bad++; $display("[TB] FAIL ar_pre_level: got %0d want 5", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ar_pre_ovf: got %0b want 1", overflow); end
        #200;
        reset = 1'b0;
        #10;
        total++; if (rd_valid !== 1'b0)   begin bad++; $display("[TB] FAIL ar_rd_valid: got %0b want 0", rd_valid); end
        total++; if (level !== 4'd0)      begin bad++; $display("[TB] FAIL ar_level: got %0d want 0", level); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("[TB] FAIL ar_ovf: got %0b want 0", overflow); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL ar_afull: got %0b want 0", almost_full); end
        @(negedge pclk);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        tick(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        total++; if (rd_data !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL ar_new_data: got %h want 000000ff", rd_data); end
        total++; if (level !== 4'd1)            begin bad++; $display("[TB] FAIL ar_new_level: got %0d want 1", level); end
    endtask

    task automatic test_random();
        int exp_lv;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            tick(($urandom_range(99) < 60), $urandom, ($urandom_range(99) < 40), ($urandom_range(99) < 5));
            exp_lv = mq.size();
            total++; if (level !== 4'(exp_lv)) begin bad++; $display("[TB] FAIL rnd_level[%0d]: got %0d want %0d", n, level, exp_lv); end
            total++; if (rd_valid !== (exp_lv != 0)) begin bad++; $display("[TB] FAIL rnd_valid[%0d]: got %0b want %0b", n, rd_valid, exp_lv != 0); end
            if (exp_lv != 0) begin
                total++; if (rd_data !== mq[0]) begin bad++; $display("[TB] FAIL rnd_data[%0d]: got %h want %h", n, rd_data, mq[0]); end
            end
            total++; if (almost_full !== (exp_lv >= AFULL)) begin bad++; $display("[TB] FAIL rnd_afull[%0d]: got %0b want %0b", n, almost_full, exp_lv >= AFULL); end
            total++; if (overflow !== m_ovf) begin bad++; $display("[TB] FAIL rnd_ovf[%0d]: got %0b want %0b", n, overflow, m_ovf); end
`ifdef RX_DROP_CNT_EN
            total++; if (drop_cnt !== 16'(m_cnt)) begin bad++; $display("[TB] FAIL rnd_drop_cnt[%0d]: got %0d want %0d", n, drop_cnt, m_cnt); end
`endif
        end
    endtask

    initial begin
        reset       = 1'b0;
        slave_valid = 1'b0;
        slave_data  = 32'h0;
        rd_ready    = 1'b0;
        ovf_clr     = 1'b0;
        m_ovf       = 1'b0;
        m_cnt       = 0;
        test_reset();
        test_single_beat();
        test_fill_overflow();
        test_full_push_pop();
        test_clear_race();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
